// File: rtl/seg_sched_if.sv
// Request/grant handshake and serial display bus of the seg_sched frame scheduler.
// master = requester/display side, slave = the scheduler.
interface seg_sched_if;
   logic        req_a;
   logic [31:0] data_a;
   logic [7:0]  blank_a;
   logic        req_b;
   logic [31:0] data_b;
   logic [7:0]  blank_b;
   logic        gnt_a;
   logic        gnt_b;
   logic        busy;
   logic        done;
   logic        seg_clk;
   logic        seg_sout;
   logic        seg_clrn;
   logic        SEG_PEN;

   modport master (
      output req_a, data_a, blank_a, req_b, data_b, blank_b,
      input  gnt_a, gnt_b, busy, done, seg_clk, seg_sout, seg_clrn, SEG_PEN
   );

   modport slave (
      input  req_a, data_a, blank_a, req_b, data_b, blank_b,
      output gnt_a, gnt_b, busy, done, seg_clk, seg_sout, seg_clrn, SEG_PEN
   );
endinterface

// File: rtl/seg_sched.sv
// Two-requester round-robin scheduler that shifts an 8-digit seven-segment frame
// MSB-first onto a serial shift-register display bus and latches it.
module seg_sched #(
   parameter int unsigned CLK_HALF = 2
) (
   input logic        clk,
   input logic        rst_n,
   seg_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StLatch} state_e;

   localparam logic [7:0] HalfLast = 8'(CLK_HALF - 1);

   state_e      state_q, state_d;
   logic [31:0] data_q;
   logic [7:0]  blank_q;
   logic [63:0] sreg_q;
   logic [63:0] pattern;
   logic [5:0]  bit_q;
   logic [7:0]  div_q;
   logic        seg_clk_q;
   logic        gnt_a_q, gnt_b_q;
   logic        last_b_q;
   logic        pen_q;
   logic        any_req, pick_b, half_end, last_bit;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign any_req  = bus.req_a | bus.req_b;
   // B wins when A is absent or A was the last one served.
   assign pick_b   = bus.req_b & (~bus.req_a | ~last_b_q);
   assign half_end = (div_q == HalfLast);
   assign last_bit = (bit_q == 6'd63);

   always_comb begin
      pattern = '1;
      for (int i = 0; i < 8; i++) begin
         pattern[i*8 +: 8] = blank_q[i] ? 8'hFF : seg7(data_q[i*4 +: 4]);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: if (seg_clk_q && half_end && last_bit) state_d = StLatch;
         StLatch: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         blank_q   <= '0;
         sreg_q    <= '1;
         bit_q     <= '0;
         div_q     <= '0;
         seg_clk_q <= 1'b0;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
         last_b_q  <= 1'b1;
         pen_q     <= 1'b0;
      end else begin
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  data_q   <= pick_b ? bus.data_b : bus.data_a;
                  blank_q  <= pick_b ? bus.blank_b : bus.blank_a;
                  gnt_a_q  <= ~pick_b;
                  gnt_b_q  <= pick_b;
                  last_b_q <= pick_b;
               end
            end
            StLoad: begin
               sreg_q    <= pattern;
               bit_q     <= '0;
               div_q     <= '0;
               seg_clk_q <= 1'b0;
            end
            StShift: begin
               if (half_end) begin
                  div_q     <= '0;
                  seg_clk_q <= ~seg_clk_q;
                  // Advance data on the falling edge so it is stable across the high phase.
                  if (seg_clk_q) begin
                     sreg_q <= {sreg_q[62:0], 1'b1};
                     bit_q  <= bit_q + 6'd1;
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            StLatch: pen_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.gnt_a    = gnt_a_q;
   assign bus.gnt_b    = gnt_b_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StLatch);
   assign bus.seg_clk  = seg_clk_q;
   assign bus.seg_sout = (state_q == StShift) ? sreg_q[63] : 1'b1;
   assign bus.seg_clrn = rst_n;
   assign bus.SEG_PEN  = (state_q == StLatch) | ((state_q == StIdle) & pen_q);

endmodule

// File: tb/tb_seg_sched.sv
// Scoreboard bench for seg_sched: two instances (CLK_HALF=2 and 1) share stimulus; each has
// a frame-level reference model feeding a queue and a monitor that decodes the serial bus.
module tb_seg_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_a, req_b;
   logic [31:0] data_a, data_b;
   logic [7:0]  blank_a, blank_b;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          is_b;
      logic [63:0] pat;
      int          gnt_cyc;
      int          done_cyc;
   } exp_t;

   logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic logic [63:0] frame_of(input logic [31:0] d, input logic [7:0] bl);
      logic [63:0] f;
      for (int k = 0; k < 8; k++) f[k*8 +: 8] = bl[k] ? 8'hFF : lut[d[k*4 +: 4]];
      return f;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int CH = 2 - g;
      localparam int FRAME = 128 * CH;

      seg_sched_if bus ();
      assign bus.req_a   = req_a;
      assign bus.data_a  = data_a;
      assign bus.blank_a = blank_a;
      assign bus.req_b   = req_b;
      assign bus.data_b  = data_b;
      assign bus.blank_b = blank_b;

      seg_sched #(.CLK_HALF(CH)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      exp_t        q[$];
      exp_t        cur;
      bit          last_b = 1'b1;
      int          free_at = 0;
      bit          active = 1'b0;
      logic [63:0] bits, last_frame;
      int          nbits = 0, last_rise = 0, frames = 0, last_span = 0;
      logic        prev_clk, prev_sout;
      bit          timing_bad, pen_bad, pen_model, idle_pen_bad, busy_bad, idle_bad, stray;

      // Reference model: one accepted request per idle window, alternating on contention.
      initial begin
         forever begin
            @(posedge clk);
            if (!rst_n) begin
               q.delete();
               last_b  = 1'b1;
               free_at = cyc + 1;
            end else if (cyc >= free_at && (req_a || req_b)) begin
               exp_t e;
               e.is_b     = req_b && (!req_a || !last_b);
               e.pat      = e.is_b ? frame_of(data_b, blank_b) : frame_of(data_a, blank_a);
               e.gnt_cyc  = cyc + 1;
               e.done_cyc = cyc + 2 + FRAME;
               q.push_back(e);
               last_b  = e.is_b;
               free_at = cyc + 3 + FRAME;
            end
         end
      end

      initial begin
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               active    = 1'b0;
               nbits     = 0;
               pen_model = 1'b0;
            end else begin
               if (bus.gnt_a && bus.gnt_b) fail($sformatf("ch%0d both gnt", CH));
               if (bus.gnt_a || bus.gnt_b) begin
                  if (active || q.size() == 0) begin
                     fail($sformatf("ch%0d unexpected gnt a=%0b b=%0b", CH, bus.gnt_a, bus.gnt_b));
                  end else begin
                     cur = q.pop_front();
                     check($sformatf("ch%0d gnt_b winner", CH), bus.gnt_b, cur.is_b);
                     check($sformatf("ch%0d gnt cycle", CH), cyc, cur.gnt_cyc);
                     check($sformatf("ch%0d SEG_PEN in load", CH), bus.SEG_PEN, 0);
                     active     = 1'b1;
                     nbits      = 0;
                     bits       = '0;
                     timing_bad = 1'b0;
                     pen_bad    = 1'b0;
                  end
               end else if (active && !bus.done && bus.SEG_PEN) begin
                  pen_bad = 1'b1;
               end
               if (bus.seg_clk && !prev_clk) begin
                  if (!active) begin
                     stray = 1'b1;
                  end else begin
                     if (nbits > 0 && cyc - last_rise != 2 * CH) timing_bad = 1'b1;
                     if (bus.seg_sout !== prev_sout) timing_bad = 1'b1;
                     last_rise = cyc;
                     bits      = {bits[62:0], bus.seg_sout};
                     nbits++;
                  end
               end else if (bus.seg_clk && prev_clk && bus.seg_sout !== prev_sout) begin
                  timing_bad = 1'b1;
               end
               if (bus.busy !== active) busy_bad = 1'b1;
               if (bus.done) begin
                  if (!active) begin
                     fail($sformatf("ch%0d unexpected done", CH));
                  end else begin
                     check($sformatf("ch%0d done cycle", CH), cyc, cur.done_cyc);
                     check($sformatf("ch%0d stream", CH), bits, cur.pat);
                     check($sformatf("ch%0d seg_clk rises", CH), nbits, 64);
                     check($sformatf("ch%0d bit timing", CH), timing_bad, 0);
                     check($sformatf("ch%0d SEG_PEN low in frame", CH), pen_bad, 0);
                     check($sformatf("ch%0d SEG_PEN at latch", CH), bus.SEG_PEN, 1);
                     last_frame = bits;
                     last_span  = cyc - cur.gnt_cyc + 1;
                     frames++;
                     active    = 1'b0;
                     pen_model = 1'b1;
                  end
               end else if (!bus.busy) begin
                  if (bus.SEG_PEN !== pen_model) idle_pen_bad = 1'b1;
                  if (bus.seg_sout !== 1'b1 || bus.seg_clk !== 1'b0) idle_bad = 1'b1;
               end
            end
            prev_clk  = bus.seg_clk;
            prev_sout = bus.seg_sout;
         end
      end
   end

   task automatic check_idle(input string name, input logic ga, input logic gb, input logic bsy,
                             input logic dn, input logic sclk, input logic sout, input logic pen,
                             input logic clrn, input logic exp_clrn);
      check({name, " gnt_a"}, ga, 0);
      check({name, " gnt_b"}, gb, 0);
      check({name, " busy"}, bsy, 0);
      check({name, " done"}, dn, 0);
      check({name, " seg_clk"}, sclk, 0);
      check({name, " seg_sout"}, sout, 1);
      check({name, " SEG_PEN"}, pen, 0);
      check({name, " seg_clrn"}, clrn, exp_clrn);
   endtask

   task automatic check_both_idle(input string name, input logic exp_clrn);
      check_idle({name, " ch2"}, g_inst[0].bus.gnt_a, g_inst[0].bus.gnt_b, g_inst[0].bus.busy,
                 g_inst[0].bus.done, g_inst[0].bus.seg_clk, g_inst[0].bus.seg_sout,
                 g_inst[0].bus.SEG_PEN, g_inst[0].bus.seg_clrn, exp_clrn);
      check_idle({name, " ch1"}, g_inst[1].bus.gnt_a, g_inst[1].bus.gnt_b, g_inst[1].bus.busy,
                 g_inst[1].bus.done, g_inst[1].bus.seg_clk, g_inst[1].bus.seg_sout,
                 g_inst[1].bus.SEG_PEN, g_inst[1].bus.seg_clrn, exp_clrn);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((g_inst[0].bus.busy || g_inst[1].bus.busy || g_inst[0].q.size() != 0 ||
                  g_inst[1].q.size() != 0) && n < 3000);
      if (n >= 3000) fail("wait_idle timeout");
   endtask

   task automatic wait_bits(input int nb);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(g_inst[0].active && g_inst[0].nbits >= nb) && n < 3000);
      if (n >= 3000) fail("wait_bits timeout");
   endtask

   task automatic pulse(input logic a, input logic b);
      @(posedge clk);
      #2;
      req_a = a;
      req_b = b;
      @(posedge clk);
      #2;
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check("seg_clrn in reset ch2", g_inst[0].bus.seg_clrn, 0);
      check("seg_clrn in reset ch1", g_inst[1].bus.seg_clrn, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int n;
      rst_n   = 1'b0;
      req_a   = 1'b0;
      req_b   = 1'b0;
      data_a  = '0;
      data_b  = '0;
      blank_a = '0;
      blank_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_both_idle("in reset", 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check_both_idle("after reset", 1'b1);

      // Single A frame with known digits.
      data_a  = 32'h0123_4567;
      blank_a = 8'h00;
      pulse(1'b1, 1'b0);
      wait_idle();
      check("ch2 frame 01234567", g_inst[0].last_frame, 64'hC0F9_A4B0_9992_82F8);
      check("ch1 frame 01234567", g_inst[1].last_frame, 64'hC0F9_A4B0_9992_82F8);
      check("ch2 gnt-to-done span", g_inst[0].last_span, 258);
      check("ch1 gnt-to-done span", g_inst[1].last_span, 130);

      // Blanked upper digits on B.
      data_b  = 32'hFFFF_FFFF;
      blank_b = 8'hF0;
      pulse(1'b0, 1'b1);
      wait_idle();
      check("ch2 frame blank", g_inst[0].last_frame, 64'hFFFF_FFFF_8E8E_8E8E);
      check("ch1 frame blank", g_inst[1].last_frame, 64'hFFFF_FFFF_8E8E_8E8E);

      // Request arriving mid-shift must be dropped.
      data_a = $urandom();
      pulse(1'b1, 1'b0);
      wait_bits(20);
      data_b = $urandom();
      pulse(1'b0, 1'b1);
      wait_idle();
      check("ch2 frames after busy req", g_inst[0].frames, 3);

      // Contention held from reset: A, B, A, B.
      do_reset();
      req_a = 1'b1;
      req_b = 1'b1;
      k = 0;
      n = 0;
      while (k < 4 && n < 3000) begin
         @(negedge clk);
         n++;
         if (g_inst[0].bus.gnt_a || g_inst[0].bus.gnt_b) begin
            check($sformatf("contention grant %0d {a,b}", k),
                  {g_inst[0].bus.gnt_a, g_inst[0].bus.gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
            k++;
         end
      end
      if (k < 4) fail("contention grant timeout");
      @(posedge clk);
      #2;
      req_a = 1'b0;
      req_b = 1'b0;
      wait_idle();

      // Mid-frame reset aborts an A frame; the next contention goes to A again.
      data_a = $urandom();
      pulse(1'b1, 1'b0);
      wait_bits(30);
      do_reset();
      @(negedge clk);
      check_both_idle("mid-frame reset", 1'b1);
      req_a = 1'b1;
      req_b = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(g_inst[0].bus.gnt_a || g_inst[0].bus.gnt_b) && n < 100);
      if (n >= 100) fail("post-reset grant timeout");
      else check("post-reset winner {a,b}", {g_inst[0].bus.gnt_a, g_inst[0].bus.gnt_b}, 2'b10);
      @(posedge clk);
      #2;
      req_a = 1'b0;
      req_b = 1'b0;
      wait_idle();

      // Random traffic.
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #2;
         req_a   = ($urandom_range(0, 15) == 0);
         req_b   = ($urandom_range(0, 15) == 0);
         data_a  = $urandom();
         data_b  = $urandom();
         blank_a = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
         blank_b = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
      end
      req_a = 1'b0;
      req_b = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      check("ch2 queue drained", g_inst[0].q.size(), 0);
      check("ch1 queue drained", g_inst[1].q.size(), 0);
      check("ch2 busy tracking", g_inst[0].busy_bad, 0);
      check("ch1 busy tracking", g_inst[1].busy_bad, 0);
      check("ch2 idle bus levels", g_inst[0].idle_bad, 0);
      check("ch1 idle bus levels", g_inst[1].idle_bad, 0);
      check("ch2 idle SEG_PEN", g_inst[0].idle_pen_bad, 0);
      check("ch1 idle SEG_PEN", g_inst[1].idle_pen_bad, 0);
      check("ch2 stray seg_clk", g_inst[0].stray, 0);
      check("ch1 stray seg_clk", g_inst[1].stray, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_sched.md
SEG_SCHED -- requirements
Module: seg_sched

Interface
REQ-001 SHALL have parameter CLK_HALF, default 2, meaning seg_clk half-period in clk cycles (legal 1..255).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have req_a  in  1  requester A (score path) frame request, level.
REQ-005 SHALL have data_a  in  32  requester A eight hex digits, digit 7 = [31:28].
REQ-006 SHALL have blank_a  in  8  requester A per-digit blank mask, bit i blanks digit i.
REQ-007 SHALL have req_b / data_b / blank_b  in  1/32/8  requester B (message path), same meaning.
REQ-008 SHALL have gnt_a, gnt_b  out  1  one-cycle acceptance pulse per requester.
REQ-009 SHALL have busy  out  1  high from acceptance until frame latched.
REQ-010 SHALL have done  out  1  one-cycle pulse when frame latched.
REQ-011 SHALL have seg_clk, seg_sout, seg_clrn, SEG_PEN  out  1 each  serial shift-register display bus.

Function
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, LATCH.
REQ-013 IDLE: when any req sampled high, SHALL select winner, register its data/blank, pulse its gnt on the next cycle, enter LOAD.
REQ-014 Arbitration SHALL be round-robin: both requesting -> grant the one not granted last; after reset, A has priority.
REQ-015 Only one gnt SHALL be high in any cycle; requests are ignored outside IDLE (no queuing).
REQ-016 LOAD (1 cycle): SHALL convert 8 digits to 64-bit pattern, per digit bits {dp,g,f,e,d,c,b,a}, active-low, dp always 1.
REQ-017 Encoding SHALL be 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E; blanked digit = FF.
REQ-018 SHIFT: SHALL send 64 bits MSB-first (digit 7 dp first, digit 0 a last).
REQ-019 Per bit: seg_sout stable, seg_clk low CLK_HALF cycles then high CLK_HALF cycles; data changes only while seg_clk low.
REQ-020 SHIFT duration SHALL be exactly 64*2*CLK_HALF cycles, counted by 6-bit bit counter and 8-bit divider counter.
REQ-021 SEG_PEN SHALL be 0 throughout LOAD and SHIFT, 1 in LATCH and IDLE after first completed frame.
REQ-022 LATCH (1 cycle): done=1, seg_clk=0, then return to IDLE; a req present that cycle is sampled on the following IDLE cycle.
REQ-023 busy SHALL be 1 in LOAD, SHIFT, LATCH; 0 in IDLE.
REQ-024 seg_clk SHALL idle low; seg_sout SHALL idle 1 outside SHIFT.
REQ-025 Request-to-gnt latency SHALL be 1 cycle; gnt-to-done latency SHALL be 1 + 128*CLK_HALF + 1 cycles.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, gnt_a=gnt_b=0, busy=0, done=0, seg_clk=0, seg_sout=1, SEG_PEN=0, seg_clrn=0, round-robin pointer to A, counters 0.
REQ-027 seg_clrn SHALL be 0 only while rst_n=0 and 1 otherwise.
REQ-028 Reset asserted mid-SHIFT SHALL abort the frame with no done pulse; SEG_PEN stays 0 until a later frame completes.

Verification
REQ-029 Single A: CLK_HALF=2, data_a=32'h0123_4567, blank_a=0 -> gnt_a 1 cycle later, captured stream C0 F9 A4 B0 99 92 82 F8 (64 bits), done 258 cycles after gnt_a.
REQ-030 Contention: req_a=req_b=1 held from reset -> grant order A, B, A, B; never both gnt high.
REQ-031 Blanking: data_b=32'hFFFF_FFFF, blank_b=8'hF0 -> digits 7..4 FF, digits 3..0 8E.
REQ-032 Timing: CLK_HALF=1 -> seg_clk period 2 cycles, 64 rising edges per frame, seg_sout never changes while seg_clk high.
REQ-033 Mid-frame reset: rst_n low at bit 30 -> next cycle all outputs at REQ-026 values, no done, next request re-arbitrated with A priority.
REQ-034 Request during busy: req_b pulsed 1 cycle mid-SHIFT -> no gnt_b, frame unaffected.
